// File: rtl/lab5_divider.sv
`default_nettype none
// ============================================================================
// Module   : lab5_divider
// Brief    : Sequential 8-bit signed restoring divider; quotient in B,
//            remainder in A, divide-by-zero/overflow flagged on X.
// Revision : 1.0 - initial release
// ============================================================================
module lab5_divider (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_a_load_b_i,
    input  logic       run_i,
    input  logic [7:0] s_i,
    output logic [7:0] aval_o,
    output logic [7:0] bval_o,
    output logic       x_o,
    output logic [6:0] ahex_u_o,
    output logic [6:0] ahex_l_o,
    output logic [6:0] bhex_u_o,
    output logic [6:0] bhex_l_o
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Two-flop synchronizers; keys rest high (released)
    logic       run_meta_q;
    logic       run_sync_q;
    logic       clr_meta_q;
    logic       clr_sync_q;
    logic [7:0] s_meta_q;
    logic [7:0] s_sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_meta_q <= 1'b1;
            run_sync_q <= 1'b1;
            clr_meta_q <= 1'b1;
            clr_sync_q <= 1'b1;
            s_meta_q   <= 8'h00;
            s_sync_q   <= 8'h00;
        end else begin
            run_meta_q <= run_i;
            run_sync_q <= run_meta_q;
            clr_meta_q <= clear_a_load_b_i;
            clr_sync_q <= clr_meta_q;
            s_meta_q   <= s_i;
            s_sync_q   <= s_meta_q;
        end
    end

    state_t     state_q, state_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic       x_q, x_d;
    logic [7:0] d_q, d_d;
    logic [2:0] cnt_q, cnt_d;
    logic       sign_b_q, sign_b_d;
    logic       sign_d_q, sign_d_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            x_q      <= 1'b0;
            d_q      <= 8'h00;
            cnt_q    <= 3'd0;
            sign_b_q <= 1'b0;
            sign_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            x_q      <= x_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            sign_b_q <= sign_b_d;
            sign_d_q <= sign_d_d;
        end
    end

    // Magnitudes are unsigned 8-bit, so |-128| is 128 and the remainder
    // (always below |D| <= 128) never overflows A when shifted.
    logic [7:0] b_mag;
    logic [7:0] s_mag;
    logic [7:0] a_shift;
    logic [7:0] b_shift;
    logic [8:0] trial;
    logic [7:0] a_neg;
    logic [7:0] b_neg;

    assign b_mag   = b_q[7] ? (~b_q + 8'd1) : b_q;
    assign s_mag   = s_sync_q[7] ? (~s_sync_q + 8'd1) : s_sync_q;
    assign a_shift = {a_q[6:0], b_q[7]};
    assign b_shift = {b_q[6:0], 1'b0};
    assign trial   = {1'b0, a_shift} - {1'b0, d_q};
    assign a_neg   = ~a_q + 8'd1;
    assign b_neg   = ~b_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        x_d      = x_q;
        d_d      = d_q;
        cnt_d    = cnt_q;
        sign_b_d = sign_b_q;
        sign_d_d = sign_d_q;

        case (state_q)
            ST_IDLE: begin
                if (!clr_sync_q) begin
                    a_d = 8'h00;
                    b_d = s_sync_q;
                    x_d = 1'b0;
                end else if (!run_sync_q) begin
                    state_d = ST_PREP;
                end
            end

            ST_PREP: begin
                d_d      = s_mag;
                sign_b_d = b_q[7];
                sign_d_d = s_sync_q[7];
                a_d      = 8'h00;
                cnt_d    = 3'd0;
                if (s_sync_q == 8'h00) begin
                    a_d     = b_q;
                    b_d     = 8'hFF;
                    x_d     = 1'b1;
                    state_d = ST_DONE;
                end else if (b_q == 8'h80 && s_sync_q == 8'hFF) begin
                    // -128 / -1 has no 8-bit representation
                    a_d     = 8'h00;
                    b_d     = 8'h80;
                    x_d     = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    b_d     = b_mag;
                    state_d = ST_ITER;
                end
            end

            ST_ITER: begin
                if (!trial[8]) begin
                    a_d = trial[7:0];
                    b_d = {b_shift[7:1], 1'b1};
                end else begin
                    a_d = a_shift;
                    b_d = b_shift;
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = ST_FIX;
                end
            end

            ST_FIX: begin
                b_d     = (sign_b_q ^ sign_d_q) ? b_neg : b_q;
                a_d     = sign_b_q ? a_neg : a_q;
                x_d     = 1'b0;
                state_d = ST_DONE;
            end

            ST_DONE: begin
                if (run_sync_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    assign aval_o   = a_q;
    assign bval_o   = b_q;
    assign x_o      = x_q;
    assign ahex_u_o = seg7(a_q[7:4]);
    assign ahex_l_o = seg7(a_q[3:0]);
    assign bhex_u_o = seg7(b_q[7:4]);
    assign bhex_l_o = seg7(b_q[3:0]);

endmodule
`default_nettype wire

// File: tb/tb_lab5_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_lab5_divider
// Brief    : Scoreboard bench for lab5_divider against a signed-divide model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lab5_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       run;
    logic [7:0] s;
    logic [7:0] aval;
    logic [7:0] bval;
    logic       x;
    logic [6:0] ahex_u, ahex_l, bhex_u, bhex_l;

    always #5 clk = ~clk;

    lab5_divider dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .clear_a_load_b_i (clr),
        .run_i            (run),
        .s_i              (s),
        .aval_o           (aval),
        .bval_o           (bval),
        .x_o              (x),
        .ahex_u_o         (ahex_u),
        .ahex_l_o         (ahex_l),
        .bhex_u_o         (bhex_u),
        .bhex_l_o         (bhex_l)
    );

    typedef logic [16:0] res_t;   // {X, A, B}
    res_t       exp_q[$];
    logic [7:0] cur_b;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg(input logic [3:0] n);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    function automatic res_t model(input logic [7:0] dd, input logic [7:0] dv);
        int n, d, q, r;
        if (dv == 8'h00) return {1'b1, dd, 8'hFF};
        if (dd == 8'h80 && dv == 8'hFF) return {1'b1, 8'h00, 8'h80};
        n = $signed(dd);
        d = $signed(dv);
        q = n / d;
        r = n % d;
        return {1'b0, r[7:0], q[7:0]};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_result(input string tag);
        res_t e;
        check_eq({tag, "_sb_pending"}, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq({tag, "_A"}, aval, e[15:8]);
            check_eq({tag, "_B"}, bval, e[7:0]);
            check_eq({tag, "_X"}, x, e[16]);
            check_eq({tag, "_BhexU"}, bhex_u, seg(e[7:4]));
            check_eq({tag, "_BhexL"}, bhex_l, seg(e[3:0]));
            check_eq({tag, "_AhexL"}, ahex_l, seg(e[11:8]));
            cur_b = e[7:0];
        end
    endtask

    task automatic load(input logic [7:0] v);
        s   = v;
        clr = 1'b0;
        tick(4);
        clr = 1'b1;
        tick(3);
        check_eq("load_B", bval, v);
        cur_b = v;
    endtask

    task automatic divide(input logic [7:0] dv, input int hold, input string tag);
        exp_q.push_back(model(cur_b, dv));
        s = dv;
        tick(3);
        run = 1'b0;
        tick(hold);
        check_result(tag);
        run = 1'b1;
        tick(4);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_A"}, aval, 8'h00);
        check_eq({tag, "_B"}, bval, 8'h00);
        check_eq({tag, "_X"}, x, 1'b0);
        check_eq({tag, "_AhexU"}, ahex_u, 7'h40);
        check_eq({tag, "_AhexL"}, ahex_l, 7'h40);
        check_eq({tag, "_BhexU"}, bhex_u, 7'h40);
        check_eq({tag, "_BhexL"}, bhex_l, 7'h40);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        clr   = 1'b1;
        run   = 1'b1;
        s     = 8'h00;
        cur_b = 8'h00;
        tick(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(2);

        // Basic, then chained divide with Run held long in DONE
        load(8'h64);
        divide(8'h07, 30, "basic");
        divide(8'h02, 60, "chain_hold");

        // Sign combinations
        load(8'h9C);
        divide(8'h07, 30, "neg_pos");
        load(8'h64);
        divide(8'hF9, 30, "pos_neg");
        load(8'h9C);
        divide(8'hF9, 30, "neg_neg");

        // Error cases, then a valid divide clears X
        load(8'h37);
        divide(8'h00, 30, "div_zero");
        load(8'h80);
        divide(8'hFF, 30, "overflow");
        load(8'h64);
        divide(8'h07, 30, "clear_x");

        // Load key pressed mid-divide is ignored
        load(8'h64);
        exp_q.push_back(model(cur_b, 8'h07));
        s = 8'h07;
        tick(3);
        run = 1'b0;
        tick(6);
        clr = 1'b0;
        tick(3);
        clr = 1'b1;
        tick(25);
        check_result("gate_load");
        run = 1'b1;
        tick(4);

        // Load and Run together: load wins, divide follows on release
        s   = 8'h50;
        clr = 1'b0;
        run = 1'b0;
        tick(6);
        check_eq("prio_load_B", bval, 8'h50);
        check_eq("prio_load_A", aval, 8'h00);
        cur_b = 8'h50;
        exp_q.push_back(model(cur_b, 8'h50));
        clr = 1'b1;
        tick(30);
        check_result("prio");
        run = 1'b1;
        tick(4);

        // Asynchronous reset in the middle of the iterations
        load(8'h64);
        s = 8'h07;
        tick(3);
        run = 1'b0;
        tick(5);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        run = 1'b1;
        tick(1);
        rst_n = 1'b1;
        tick(20);
        check_reset_outputs("idle_after_rst");
        cur_b = 8'h00;
        load(8'h9C);
        divide(8'h07, 30, "post_rst");

        check_eq("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lab5_divider.md
# lab5_divider

Sequential 8-bit signed restoring divider that is the inverse companion of the lab 5 shift-add multiplier. It uses the same board I/O: switches S, active-low ClearA_LoadB and Run keys, A/B registers with an X flag, and four hex displays. The dividend is loaded into B from the switches, and Run divides B by the divisor on S. The quotient is left in B, the remainder in A, and error status in X.

## Interface
- No parameters; data width fixed at 8.
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-low reset
- ClearA_LoadB  in  1  active-low key; in IDLE: A<=0, B<=S, X<=0
- Run  in  1  active-low key; starts a divide, must be released before the next one
- S  in  8  switches: dividend on load, divisor on Run (two's complement)
- Aval  out  8  A register (remainder)
- Bval  out  8  B register (quotient)
- X  out  1  error flag: divide-by-zero or overflow
- AhexU, AhexL, BhexU, BhexL  out  7 each  active-low 7-seg (gfedcba) of A[7:4], A[3:0], B[7:4], B[3:0]

## Operation
- Input synchronization:
  - Run, ClearA_LoadB and S each pass through 2-flop synchronizers.
  - Synchronizer reset values: keys 1 (released), S 0x00.
- State machine: IDLE -> PREP -> ITER (x8, 3-bit counter) -> FIX -> DONE -> IDLE.
- IDLE:
  - Synced ClearA_LoadB low loads registers. It has priority over Run in the same cycle.
  - Otherwise synced Run low -> PREP.
- PREP:
  - Latch divisor D = S_sync.
  - Record sign of dividend (B[7]) and divisor.
  - Replace B with |B| and D with |D|. Magnitudes are held unsigned 8-bit, so |-128| = 128.
  - Clear A.
  - D == 0 -> DONE directly: A <= original B, B <= 0xFF, X <= 1.
  - B == 0x80 and D == 0xFF -> DONE directly: A <= 0x00, B <= 0x80, X <= 1.
- ITER (restoring step, one per cycle):
  - {A,B} <= {A,B} << 1.
  - Compute 9-bit trial = A_shifted - D.
  - If trial is non-negative: A <= trial[7:0] and B[0] <= 1; else B[0] <= 0.
  - Counter increments each ITER cycle; after the 8th ITER -> FIX.
- FIX:
  - Quotient B is negated if the signs differed.
  - Remainder A is negated if the dividend was negative.
  - Division truncates toward zero; the remainder takes the dividend's sign. X <= 0.
- DONE: holds all registers until synced Run is high, then -> IDLE.
- Chaining: a subsequent Run divides the current B (previous quotient) by the new S without a reload.
- ClearA_LoadB is ignored outside IDLE. S changes after PREP do not affect the running operation.
- Aval/Bval show the live registers. They carry intermediate magnitudes during ITER and are valid only in DONE/IDLE.

## Timing
- Reset low (async, any state, including mid-ITER):
  - state IDLE, A = B = 0x00, X = 0, counter 0.
  - All hex outputs 7'h40 ("0").
  - Synchronizers go to their reset values.
- Release of reset is synchronous. If Run is held low through release, a divide starts after synchronizer latency.
- Key/switch to internal latency: 2 cycles.
- Latency from the edge on which IDLE samples synced Run low:
  - PREP at +1.
  - ITER at +2..+9.
  - FIX at +10.
  - Results valid and DONE at +11. Maximum 13 cycles from the Run pin.
- Error cases reach DONE with final values at +2.
- Hex outputs are combinational from A/B and track them with zero latency.
- Run held low in DONE: no new operation. A second divide needs release then press, min 1 cycle in IDLE between operations.

## Test plan
- Basic: Reset, S=0x64, pulse ClearA_LoadB, S=0x07, Run low 30 cycles -> B=0x0E, A=0x02, X=0, BhexU/L show "0E".
- Signs: dividend 0x9C / S=0x07 -> B=0xF2, A=0xFE. Dividend 0x64 / S=0xF9 -> B=0xF2, A=0x02. Dividend 0x9C / S=0xF9 -> B=0x0E, A=0xFE. All with X=0.
- Errors: dividend 0x37 / S=0x00 -> B=0xFF, A=0x37, X=1. Dividend 0x80 / S=0xFF -> B=0x80, A=0x00, X=1. Next valid divide clears X.
- Chaining and run-hold: after the basic case, release Run, S=0x02, Run -> B=0x07, A=0x00. Holding Run low 40 cycles in DONE does not repeat the divide.
- Load priority and gating: ClearA_LoadB asserted during ITER is ignored and the result is unchanged. ClearA_LoadB and Run asserted together in IDLE -> load happens, then the divide starts once ClearA_LoadB is released.
- Async reset mid-ITER (5 cycles after Run): outputs go to 0x00/0/7'h40 before the next clock edge. After release with Run high, the block stays in IDLE and a fresh load/divide gives correct results.
